bcd_digit_display: RTL

BCD_DIGIT_DISPLAY -- requirements
Module: bcd_digit_display

---
 rtl/bcd_disp_pkg.sv | 27 ++
 rtl/bcd_digit_display_if.sv | 31 +++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/bcd_digit_display.sv | 98 +++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_disp_pkg
// Brief    : Shared constants for the BCD digit display (segment codes, size).
// Revision : 1.0
// ============================================================================
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] scan_idx_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_display_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_display_if
// Brief    : Digit entry inputs and display/status outputs of the display.
// Revision : 1.0
// ============================================================================
interface bcd_digit_display_if;
  import bcd_disp_pkg::*;

  logic [3:0]              bcd_in;
  logic                    bcd_valid;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [2:0]              digit_cnt;
  logic                    overflow;
  logic                    bcd_err;
  logic [NUM_DIGITS-1:0]   an_out;
  logic [6:0]              seg_out;

  modport master (
    output bcd_in, bcd_valid, clear,
    input  digits_out, digit_cnt, overflow, bcd_err, an_out, seg_out
  );

  modport slave (
    input  bcd_in, bcd_valid, clear,
    output digits_out, digit_cnt, overflow, bcd_err, an_out, seg_out
  );

endinterface
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg
// Brief    : Combinational BCD to active-low seven-segment decoder.
// Revision : 1.0
// ============================================================================
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_digit_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_display
// Brief    : Four-digit keyed BCD entry buffer with multiplexed 7-seg scan.
// Revision : 1.0
// ============================================================================
module bcd_digit_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_CNT = 50000
) (
  input  logic               clk,
  input  logic               rst,
  bcd_digit_display_if.slave bus
);

  localparam int unsigned     PW           = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [PW-1:0]   C_PRESC_LAST = PW'(REFRESH_CNT - 1);
  localparam logic [2:0]      C_CNT_MAX    = 3'(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [2:0]              r_cnt;
  logic                    r_ovf;
  logic                    r_err;
  logic [PW-1:0]           r_presc;
  scan_idx_t               r_scan;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;

  logic                    w_accept;
  logic                    w_bad;
  logic [3:0]              w_cur_digit;
  logic [6:0]              w_cur_seg;
  logic                    w_blank;

  assign w_accept    = bus.bcd_valid && (bus.bcd_in <= 4'd9);
  assign w_bad       = bus.bcd_valid && (bus.bcd_in >  4'd9);
  assign w_cur_digit = r_digits[{r_scan, 2'b00} +: 4];
  // Unfilled positions go dark, but the units position always shows a digit
  assign w_blank     = (r_scan != 2'd0) && ({1'b0, r_scan} >= r_cnt);

  bcd_to_7seg u_dec (
    .i_bcd (w_cur_digit),
    .o_seg (w_cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_digits <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_digits <= {r_digits[4*NUM_DIGITS-5:0], bus.bcd_in};
        if (r_cnt == C_CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_scan  <= '0;
    end else if (r_presc == C_PRESC_LAST) begin
      r_presc <= '0;
      r_scan  <= r_scan + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(NUM_DIGITS'(1) << r_scan);
      r_seg <= w_blank ? SEG_BLANK : w_cur_seg;
    end
  end

  assign bus.digits_out = r_digits;
  assign bus.digit_cnt  = r_cnt;
  assign bus.overflow   = r_ovf;
  assign bus.bcd_err    = r_err;
  assign bus.an_out     = r_an;
  assign bus.seg_out    = r_seg;

endmodule
`default_nettype wire
